// File: rtl/sram_seq_pkg.sv
// sram_seq_pkg: shared types and helpers for the SRAM request sequencer.
// Holds the FSM state enum, the request struct at default widths, and a
// width helper for counters that must hold the value n.
package sram_seq_pkg;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 256;
  localparam int DEF_MASK_W = 32;
  typedef enum logic {INIT, RUN} state_e;
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic                  write;
    logic [DEF_DATA_W-1:0] wdata;
    logic [DEF_MASK_W-1:0] wmask;
  } req_t;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/sram_req_sequencer_if.sv
// sram_req_sequencer_if: controller-side request/response bus.
// master = cache controller (drives requests, consumes responses)
// slave  = sequencer (accepts requests, returns read data in order)
interface sram_req_sequencer_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 256,
  parameter int MASK_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  modport master (
    output req_valid, req_addr, req_write, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );
  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/sram_resp_fifo.sv
// sram_resp_fifo: DEPTH x W response FIFO with wrap-around pointers.
// Ports: clk/rst (async active-high), push/din, pop/dout (registered storage,
// no flow-through), occ occupancy, full/empty flags.
module sram_resp_fifo import sram_seq_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int W = 256,
  localparam int OW = cnt_w(DEPTH),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [OW-1:0] occ,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [OW-1:0] occ_q, occ_d;
  always_comb begin
    wp_d  = push ? (wp_q == PW'(DEPTH - 1) ? '0 : wp_q + 1'b1) : wp_q;
    rp_d  = pop ? (rp_q == PW'(DEPTH - 1) ? '0 : rp_q + 1'b1) : rp_q;
    occ_d = occ_q + OW'(push) - OW'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      occ_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      occ_q <= occ_d;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wp_q] <= din;
  assign dout  = mem_q[rp_q];
  assign occ   = occ_q;
  assign full  = occ_q == OW'(DEPTH);
  assign empty = occ_q == '0;
  // The upstream admission check reserves a slot for every in-flight read.
  assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: rtl/sram_req_sequencer.sv
// sram_req_sequencer: turns a valid/ready request stream into RW0 cycles of a
// single-port SRAM wrapper, buffering one-cycle-latency read data in order.
// Ports: clock/reset (async active-high); bus (slave side of request/response
// interface); init_done after the zero-fill sweep; RW0_* to/from the wrapper.
module sram_req_sequencer import sram_seq_pkg::*; #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 256,
  parameter int MASK_W = 32,
  parameter int INIT_ON_RESET = 1,
  parameter int RESP_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  sram_req_sequencer_if.slave   bus,
  output logic                  init_done,
  output logic [ADDR_W-1:0]     RW0_addr,
  output logic                  RW0_en,
  output logic                  RW0_wmode,
  output logic [DATA_W-1:0]     RW0_wdata,
  output logic [MASK_W-1:0]     RW0_wmask,
  input  logic [DATA_W-1:0]     RW0_rdata
);
  localparam int OW = cnt_w(RESP_DEPTH);
  localparam int SW = OW + 1;
  localparam state_e RST_STATE = INIT_ON_RESET != 0 ? INIT : RUN;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic              inflight_q, inflight_d;
  logic [OW-1:0]     occ;
  logic              full, empty, pop, accept, in_init, last;
  always_comb begin
    in_init       = state_q == INIT;
    last          = in_init && &cnt_q;
    pop           = !empty && bus.resp_ready;
    // Reserve a buffer slot for the read already on the SRAM port; a pop in
    // this cycle frees one, keeping full throughput with two entries.
    bus.req_ready = init_done_q &&
                    (SW'(occ) + SW'(inflight_q) - SW'(pop)) < SW'(RESP_DEPTH);
    accept        = bus.req_valid && bus.req_ready;
    state_d       = last ? RUN : state_q;
    cnt_d         = in_init ? cnt_q + 1'b1 : cnt_q;
    init_done_d   = init_done_q || last || !in_init;
    inflight_d    = accept && !bus.req_write;
    // Gating with reset keeps the port idle while reset is held in INIT.
    RW0_en        = in_init ? !reset : accept;
    RW0_wmode     = in_init ? !reset : bus.req_write;
    RW0_addr      = in_init ? cnt_q : bus.req_addr;
    RW0_wdata     = in_init ? '0 : bus.req_wdata;
    RW0_wmask     = in_init ? {MASK_W{!reset}} : (bus.req_write ? bus.req_wmask : '0);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      inflight_q  <= inflight_d;
    end
  end
  sram_resp_fifo #(.DEPTH(RESP_DEPTH), .W(DATA_W)) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (inflight_q),
    .din   (RW0_rdata),
    .pop   (pop),
    .dout  (bus.resp_rdata),
    .occ   (occ),
    .full  (full),
    .empty (empty)
  );
  assign bus.resp_valid = !empty;
  assign init_done      = init_done_q;
endmodule

// File: tb/tb_sram_req_sequencer.sv
// tb_sram_req_sequencer: directed self-checking bench with an SRAM model.
module tb_sram_req_sequencer;
  localparam int AW = 9;
  localparam int DW = 256;
  localparam int MW = 32;
  localparam int CW = DW + 64;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  sram_req_sequencer_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) bus ();
  logic          init_done, RW0_en, RW0_wmode;
  logic [AW-1:0] RW0_addr;
  logic [DW-1:0] RW0_wdata, RW0_rdata;
  logic [MW-1:0] RW0_wmask;
  sram_req_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .INIT_ON_RESET(1), .RESP_DEPTH(2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .init_done (init_done),
    .RW0_addr  (RW0_addr),
    .RW0_en    (RW0_en),
    .RW0_wmode (RW0_wmode),
    .RW0_wdata (RW0_wdata),
    .RW0_wmask (RW0_wmask),
    .RW0_rdata (RW0_rdata)
  );
  logic [DW-1:0] mem [2**AW];
  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) begin
        for (int l = 0; l < MW; l++)
          if (RW0_wmask[l]) mem[RW0_addr][l*8 +: 8] <= RW0_wdata[l*8 +: 8];
      end else begin
        RW0_rdata <= mem[RW0_addr];
      end
    end
  end
  int checks = 0;
  int fails = 0;
  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic nxt();
    @(negedge clock);
    #1;
  endtask
  task automatic chk_reset(input string tag);
    chk(tag, CW'({bus.req_ready, bus.resp_valid, init_done, RW0_en, RW0_wmode, RW0_addr, RW0_wmask}), '0);
  endtask
  task automatic sweep(input string tag);
    for (int i = 0; i < 2**AW; i++) begin
      chk($sformatf("%s_%0d", tag, i),
          CW'({RW0_en, RW0_wmode, RW0_addr, RW0_wmask, bus.req_ready, init_done, RW0_wdata == '0}),
          CW'({1'b1, 1'b1, AW'(i), {MW{1'b1}}, 1'b0, 1'b0, 1'b1}));
      nxt();
    end
    chk({tag, "_done"}, CW'({init_done, bus.req_ready, RW0_en}), CW'(3'b110));
  endtask
  task automatic wr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = a; bus.req_wdata = d; bus.req_wmask = m;
    #1;
    chk(tag, CW'({bus.req_ready, RW0_en, RW0_wmode, RW0_addr, RW0_wmask}), CW'({1'b1, 1'b1, 1'b1, a, m}));
    nxt();
    bus.req_valid = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = a; bus.req_wmask = '1;
    #1;
    chk({tag, "_issue"}, CW'({bus.req_ready, RW0_en, RW0_wmode, RW0_addr, RW0_wmask}), CW'({1'b1, 1'b1, 1'b0, a, {MW{1'b0}}}));
    nxt();
    bus.req_valid = 1'b0;
    #1;
    chk({tag, "_t1"}, CW'(bus.resp_valid), CW'(1'b0));
    nxt();
    chk({tag, "_t2"}, CW'({bus.resp_valid, bus.resp_rdata}), CW'({1'b1, exp}));
    nxt();
    chk({tag, "_drained"}, CW'(bus.resp_valid), CW'(1'b0));
  endtask
  function automatic logic [DW-1:0] dat(input int i);
    return {8{32'hC0DE_0000 | 32'(i)}};
  endfunction
  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_wmask = '0; bus.resp_ready = 1'b1;
    #12;
    chk_reset("reset_state");
    @(negedge clock);
    reset = 1'b0;
    #1;
    sweep("sweep1");
    wr("wr5", 9'd5, {32{8'hA5}}, '1);
    rd("rd5", 9'd5, {32{8'hA5}});
    wr("wr7_lane0", 9'd7, '1, 32'h0000_0001);
    rd("rd7", 9'd7, {248'b0, 8'hFF});
    for (int i = 0; i < 16; i++) wr($sformatf("wr_fill%0d", i), AW'(16 + i), dat(i), '1);
    for (int c = 0; c < 18; c++) begin
      bus.req_valid = c < 16; bus.req_write = 1'b0; bus.req_addr = AW'(16 + c);
      #1;
      if (c < 16) chk($sformatf("burst_ready%0d", c), CW'(bus.req_ready), CW'(1'b1));
      if (c >= 2) chk($sformatf("burst_resp%0d", c - 2), CW'({bus.resp_valid, bus.resp_rdata}), CW'({1'b1, dat(c - 2)}));
      nxt();
    end
    chk("burst_idle", CW'(bus.resp_valid), CW'(1'b0));
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_addr = 9'd16;
    #1;
    chk("bp_c0", CW'(bus.req_ready), CW'(1'b1));
    nxt();
    bus.req_addr = 9'd17;
    #1;
    chk("bp_c1", CW'(bus.req_ready), CW'(1'b1));
    nxt();
    bus.req_addr = 9'd18;
    for (int c = 2; c < 5; c++) begin
      #1;
      chk($sformatf("bp_c%0d", c), CW'({bus.req_ready, RW0_en, bus.resp_valid, bus.resp_rdata}), CW'({1'b0, 1'b0, 1'b1, dat(0)}));
      nxt();
    end
    bus.resp_ready = 1'b1;
    #1;
    chk("bp_resume", CW'({bus.req_ready, RW0_en, RW0_addr, bus.resp_valid, bus.resp_rdata}), CW'({1'b1, 1'b1, 9'd18, 1'b1, dat(0)}));
    nxt();
    bus.req_addr = 9'd19;
    #1;
    chk("bp_d1", CW'({bus.req_ready, bus.resp_valid, bus.resp_rdata}), CW'({1'b1, 1'b1, dat(1)}));
    nxt();
    bus.req_valid = 1'b0;
    #1;
    chk("bp_d2", CW'({bus.resp_valid, bus.resp_rdata}), CW'({1'b1, dat(2)}));
    nxt();
    chk("bp_d3", CW'({bus.resp_valid, bus.resp_rdata}), CW'({1'b1, dat(3)}));
    nxt();
    chk("bp_empty", CW'(bus.resp_valid), CW'(1'b0));
    bus.resp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_addr = 9'd16;
    nxt();
    bus.req_valid = 1'b0;
    nxt();
    chk("held_resp", CW'(bus.resp_valid), CW'(1'b1));
    reset = 1'b1;
    #1;
    chk_reset("reset_run");
    nxt();
    bus.resp_ready = 1'b1;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 200; i++) nxt();
    chk("sweep_at200", CW'({RW0_en, RW0_addr, init_done}), CW'({1'b1, 9'd200, 1'b0}));
    reset = 1'b1;
    #1;
    chk_reset("reset_init");
    nxt();
    reset = 1'b0;
    #1;
    sweep("sweep2");
    rd("rd_zeroed", 9'd5, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
